// File: rtl/frame_sink.sv
// Drains one frame from a first-word-fall-through FIFO into a raster-addressed
// frame-buffer write port, tracking x/y, pulsing frame_done and summing pixels.
module frame_sink #(
  parameter int DWIDTH     = 8,
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  fifo_rd_en,
  input  logic [DWIDTH-1:0]     fifo_dout,
  input  logic                  fifo_empty,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0]     mem_din,
  output logic                  busy,
  output logic                  frame_done,
  output logic [31:0]           checksum
);

  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [XW-1:0]           x_q, x_d;
  logic [YW-1:0]           y_q, y_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DWIDTH-1:0]       mem_din_q, mem_din_d;
  logic                    done_q, done_d;
  logic [31:0]             sum_q, sum_d;

  // Abort wins over a pending read, so the aborted cycle never consumes a pixel.
  assign fifo_rd_en = (state_q == DRAIN) && !fifo_empty && !abort;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    addr_d     = addr_q;
    wr_en_d    = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    done_d     = 1'b0;
    sum_d      = sum_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRAIN;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          sum_d   = '0;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (fifo_rd_en) begin
          wr_en_d    = 1'b1;
          mem_addr_d = addr_q;
          mem_din_d  = fifo_dout;
          sum_d      = sum_q + 32'(fifo_dout);
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              addr_d  = '0;
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              y_d    = y_q + YW'(1);
              addr_d = addr_q + ADDR_WIDTH'(1);
            end
          end else begin
            x_d    = x_q + XW'(1);
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      done_q     <= 1'b0;
      sum_q      <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      addr_q     <= addr_d;
      wr_en_q    <= wr_en_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      done_q     <= done_d;
      sum_q      <= sum_d;
    end
  end

  assign mem_wr_en  = wr_en_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign frame_done = done_q;
  assign checksum   = sum_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_frame_sink.sv
// Scoreboard bench for frame_sink: a 4x3 instance for the directed scenarios and
// a 256x256 16-bit instance for checksum wrap-around.
module tb_frame_sink;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // ---------------- small DUT (4x3, 8-bit) ----------------
  logic       reset, start, abort;
  logic       fifo_rd_en, fifo_empty;
  logic [7:0] fifo_dout;
  logic       mem_wr_en, busy, frame_done;
  logic [3:0] mem_addr;
  logic [7:0] mem_din;
  logic [31:0] checksum;

  frame_sink #(.DWIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(3), .ADDR_WIDTH(4)) u_dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_din(mem_din),
    .busy(busy), .frame_done(frame_done), .checksum(checksum)
  );

  // FWFT FIFO model: pointer advances with NBA so the DUT samples the old head.
  logic [7:0] fifo_mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  assign fifo_dout  = fifo_mem[rd_ptr];
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clock) if (fifo_rd_en) rd_ptr <= rd_ptr + 8'd1;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic       done;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic expect_wr(input logic [3:0] a, input logic [7:0] d, input logic dn);
    exp_t e;
    e.addr = a; e.data = d; e.done = dn;
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (frame_done) begin ok = 1; break; end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // Monitor: every presented write is matched against the scoreboard head.
  always @(negedge clock) begin
    exp_t e;
    if (mem_wr_en) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%0h with nothing expected", mem_addr, mem_din);
      end else begin
        e = sb.pop_front();
        if (mem_addr !== e.addr || mem_din !== e.data || frame_done !== e.done) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%0h done=%0b, expected addr=%0d data=%0h done=%0b",
                   mem_addr, mem_din, frame_done, e.addr, e.data, e.done);
        end
      end
    end else if (frame_done) begin
      checks++; errors++;
      $display("FAIL done_without_write: frame_done=1 mem_wr_en=0, expected no pulse");
    end
  end

  // ---------------- big DUT (256x256, 16-bit) ----------------
  logic        reset_b, start_b, abort_b;
  logic        b_rd_en, b_wr_en, b_busy, b_done;
  logic        b_empty;
  logic [15:0] b_dout, b_addr, b_din;
  logic [31:0] b_checksum;
  int          big_pops = 0;
  int          big_writes = 0;
  bit          big_finished = 0;

  frame_sink #(.DWIDTH(16), .IMG_WIDTH(256), .IMG_HEIGHT(256), .ADDR_WIDTH(16)) u_big (
    .clock(clock), .reset(reset_b), .start(start_b), .abort(abort_b),
    .fifo_rd_en(b_rd_en), .fifo_dout(b_dout), .fifo_empty(b_empty),
    .mem_wr_en(b_wr_en), .mem_addr(b_addr), .mem_din(b_din),
    .busy(b_busy), .frame_done(b_done), .checksum(b_checksum)
  );

  always @(posedge clock) if (b_rd_en) big_pops++;
  always @(negedge clock) if (b_wr_en) big_writes++;

  initial begin
    bit ok;
    reset_b = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    b_empty = 1'b0; b_dout = 16'hFFFF;
    #22 reset_b = 1'b1;
    @(negedge clock); start_b = 1'b1;
    @(negedge clock); start_b = 1'b0;
    ok = 0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clock);
      if (b_done) begin ok = 1; break; end
    end
    #1;
    check("big_done_seen", 32'(ok), 32'd1);
    check("big_checksum_wrap", b_checksum, 32'hFFFF0000);
    check("big_last_addr", 32'(b_addr), 32'd65535);
    check("big_last_data", 32'(b_din), 32'h0000FFFF);
    check("big_write_count", 32'(big_writes), 32'd65536);
    check("big_pop_count", 32'(big_pops), 32'd65536);
    @(negedge clock);
    check("big_busy_after", 32'(b_busy), 32'd0);
    big_finished = 1;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [7:0] base;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    #1;
    check("rst_wr_en", 32'(mem_wr_en), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_din", 32'(mem_din), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_checksum", checksum, 0);
    check("rst_busy", 32'(busy), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Full frame 0..11
    for (int i = 0; i < 12; i++) begin
      load(8'(i));
      expect_wr(4'(i), 8'(i), i == 11);
    end
    pulse_start();
    check("full_busy", 32'(busy), 1);
    wait_done("full_done_seen");
    check("full_checksum", checksum, 32'd66);
    check("full_busy_in_done", 32'(busy), 1);
    @(negedge clock);
    check("full_busy_falls", 32'(busy), 0);
    #1 check("full_sb_empty", 32'(sb.size()), 0);

    // Bubbles after pixel 5
    for (int i = 0; i < 6; i++) load(8'(i));
    for (int i = 0; i < 12; i++) expect_wr(4'(i), 8'(i), i == 11);
    pulse_start();
    for (int i = 0; i < 50 && !fifo_empty; i++) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bubble_no_write", 32'(mem_wr_en), 0);
    end
    for (int i = 6; i < 12; i++) load(8'(i));
    wait_done("bubble_done_seen");
    check("bubble_checksum", checksum, 32'd66);
    @(negedge clock);
    #1 check("bubble_sb_empty", 32'(sb.size()), 0);

    // Abort while pixel 7 is at the head
    base = rd_ptr;
    for (int i = 0; i < 12; i++) load(8'(i));
    for (int i = 0; i < 7; i++) expect_wr(4'(i), 8'(i), 1'b0);
    pulse_start();
    for (int i = 0; i < 50 && (rd_ptr - base) != 8'd7; i++) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_idle", 32'(busy), 0);
    repeat (3) @(negedge clock);
    check("abort_checksum", checksum, 32'd21);
    check("abort_pops", 32'(8'(rd_ptr - base)), 7);
    #1 check("abort_sb_empty", 32'(sb.size()), 0);
    wr_ptr = rd_ptr;

    // Back-to-back frames of 0xFF
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 12; i++) begin
        load(8'hFF);
        expect_wr(4'(i), 8'hFF, i == 11);
      end
    pulse_start();
    wait_done("b2b_done1_seen");
    check("b2b_checksum1", checksum, 32'd3060);
    @(negedge clock);
    check("b2b_idle_gap", 32'(busy), 0);
    check("b2b_checksum_held", checksum, 32'd3060);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("b2b_checksum_cleared", checksum, 0);
    wait_done("b2b_done2_seen");
    check("b2b_checksum2", checksum, 32'd3060);
    @(negedge clock);
    #1 check("b2b_sb_empty", 32'(sb.size()), 0);

    // Asynchronous reset after pixel 4
    base = rd_ptr;
    for (int i = 0; i < 12; i++) load(8'(i + 1));
    for (int i = 0; i < 5; i++) expect_wr(4'(i), 8'(i + 1), 1'b0);
    pulse_start();
    for (int i = 0; i < 50 && (rd_ptr - base) != 8'd5; i++) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("arst_wr_en", 32'(mem_wr_en), 0);
    check("arst_addr", 32'(mem_addr), 0);
    check("arst_din", 32'(mem_din), 0);
    check("arst_checksum", checksum, 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_rd_en", 32'(fifo_rd_en), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    check("arst_no_pops", 32'(8'(rd_ptr - base)), 5);
    check("arst_idle", 32'(busy), 0);
    #1 check("arst_sb_empty", 32'(sb.size()), 0);
    wr_ptr = rd_ptr;

    for (int i = 0; i < 80000 && !big_finished; i++) @(negedge clock);
    check("big_finished", 32'(big_finished), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_sink.md
Name: frame_sink

Overview:
- Drains one processed frame (e.g. sobel output) from a first-word-fall-through FIFO into a raster-addressed frame-buffer memory write port.
- Tracks x/y position, raises a one-cycle done pulse after the last pixel, and accumulates a 32-bit pixel checksum for bench and ILA comparison against the C model.
- Sits at the consumer end of the filter's output FIFO, opposite the filter that writes it.

Parameters:
- DWIDTH, 8, pixel width in bits (FIFO dout and memory data).
- IMG_WIDTH, 720, pixels per row, >= 2.
- IMG_HEIGHT, 540, rows per frame, >= 2.
- ADDR_WIDTH, 19, memory address width; must satisfy 2^ADDR_WIDTH >= IMG_WIDTH*IMG_HEIGHT.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin draining a frame; sampled only in IDLE.
- abort  in  1  synchronous abandon of the current frame; sampled only in DRAIN.
- fifo_rd_en  out  1  FIFO pop, combinational.
- fifo_dout  in  DWIDTH  FIFO head data, valid whenever fifo_empty=0 (FWFT).
- fifo_empty  in  1  FIFO empty flag.
- mem_wr_en  out  1  memory write strobe, registered.
- mem_addr  out  ADDR_WIDTH  write address, registered.
- mem_din  out  DWIDTH  write data, registered.
- busy  out  1  1 when state != IDLE.
- frame_done  out  1  one-cycle pulse, registered.
- checksum  out  32  running sum of pixels in the current or last frame.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (reset=0), effective immediately regardless of clock:
  - state=IDLE; x=0; y=0; addr counter=0.
  - mem_wr_en=0, mem_addr=0, mem_din=0, frame_done=0, checksum=0.
  - Any frame in progress is discarded; no further writes until a new start.
- States: IDLE, DRAIN, DONE; 2-bit encoding, registered.
- IDLE:
  - fifo_rd_en=0, mem_wr_en=0.
  - start=1 -> DRAIN next cycle; x, y and addr cleared to 0; checksum cleared to 0.
- DRAIN:
  - fifo_rd_en = !fifo_empty && !abort, combinational.
  - On a pop in cycle t, in cycle t+1:
    - mem_wr_en=1; mem_addr = addr; mem_din = fifo_dout captured at t.
    - checksum += zero-extended fifo_dout, modulo 2^32.
  - Write latency is exactly 1 cycle from pop.
  - No pop in a cycle -> mem_wr_en=0 next cycle; counters and checksum hold.
  - Position on each pop: x increments and addr increments. At x=IMG_WIDTH-1, x wraps to 0 and y increments. Address is therefore y*IMG_WIDTH+x, contiguous.
  - Pop of the last pixel (x=IMG_WIDTH-1, y=IMG_HEIGHT-1) -> DONE next cycle; x, y and addr wrap to 0.
  - abort=1 -> IDLE next cycle with no pop that cycle (abort beats read); checksum holds its partial value; frame_done is not raised.
  - start is ignored while in DRAIN.
- DONE:
  - Lasts one cycle; fifo_rd_en=0.
  - frame_done=1 in the same cycle as the last pixel's mem_wr_en.
  - Next state IDLE unconditionally; start is ignored in DONE.
- busy is a decode of the registered state: 0 in IDLE, 1 in DRAIN and DONE.
- fifo_empty asserted mid-row: stall with no write and no position change; resume seamlessly when data returns.
- Throughput: one pixel per cycle when the FIFO never empties.
- Frame latency: IMG_WIDTH*IMG_HEIGHT + 1 cycles from first pop to frame_done.
- Back-to-back frames: start may be asserted in the cycle after DONE (in IDLE), giving a minimum 2-cycle gap between frames.
- checksum stays valid after frame_done until the next start.

Test Plan:
- Use IMG_WIDTH=4, IMG_HEIGHT=3 throughout.
- Full frame: FIFO preloaded with 0..11, start pulse -> 12 consecutive writes, addr 0..11 with data 0..11; frame_done high with the addr-11 write; checksum=66; busy falls the cycle after.
- Bubbles: FIFO empty for 3 cycles after pixel 5 -> no mem_wr_en during the gap; pixel 6 written at addr 6; final checksum=66.
- Abort: abort asserted in the cycle pixel 7 is at the head -> only addr 0..6 written; state IDLE; frame_done never 1; checksum=21.
- Back-to-back: two frames of 0xFF, start asserted the cycle after frame_done -> second frame writes addr 0..11 again; checksum=3060 (12*255).
- Reset mid-frame: reset low after pixel 4 -> all outputs 0 immediately without waiting for a clock edge; after release with no start, no writes occur even with FIFO non-empty.
- Checksum wrap: DWIDTH=16, IMG_WIDTH=IMG_HEIGHT=256, all pixels 0xFFFF -> checksum = (65536*65535) mod 2^32 = 0xFFFF0000.
